// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
//
// Shares one single-port RAM between two requesters: r0 (CPU data port) and
// r1 (loader/DMA). Each access is a fixed four-state sequence:
//   IDLE  -> sample requests, pick a grantee, latch its command fields
//   ISSUE -> drive the RAM for exactly one cycle
//   WAIT  -> RAM read data is valid; capture it (reads only)
//   DONE  -> one-cycle completion pulse to the grantee
// When both requesters ask in the same IDLE cycle, the one that was not
// granted last wins, so continuous contention alternates strictly.
//
// Every output is either a register or a decode of the state register, so
// no input reaches an output combinationally.
//
// Ports
//   axi_aclk_i, axi_aresetn_i      clock, asynchronous active-low reset
//   rN_req_i                       access request, held until rN_done_o
//   rN_wen_i                       1 = write, 0 = read
//   rN_addr_i                      word address
//   rN_wdata_i, rN_wstrb_i         write data and byte strobes
//   rN_done_o                      one-cycle completion pulse
//   rdata_o                        read data, qualified by rN_done_o
//   busy_o                         an access is in progress
//   ram_en_o, ram_wen_o            RAM enable / write enable
//   ram_addr_o                     RAM word address
//   ram_wdata_o, ram_wstrb_o       RAM write data / byte strobes
//   ram_rdata_i                    RAM read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  axi_aclk_i,
    input  logic                  axi_aresetn_i,

    input  logic                  r0_req_i,
    input  logic                  r0_wen_i,
    input  logic [ADDR_WIDTH-1:0] r0_addr_i,
    input  logic [31:0]           r0_wdata_i,
    input  logic [3:0]            r0_wstrb_i,
    output logic                  r0_done_o,

    input  logic                  r1_req_i,
    input  logic                  r1_wen_i,
    input  logic [ADDR_WIDTH-1:0] r1_addr_i,
    input  logic [31:0]           r1_wdata_i,
    input  logic [3:0]            r1_wstrb_i,
    output logic                  r1_done_o,

    output logic [31:0]           rdata_o,
    output logic                  busy_o,

    output logic                  ram_en_o,
    output logic                  ram_wen_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [31:0]           ram_wdata_o,
    output logic [3:0]            ram_wstrb_o,
    input  logic [31:0]           ram_rdata_i
);

    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Requester identity: 0 = r0, 1 = r1.
    logic last_grant;
    logic grant;
    logic grant_next;
    logic any_req;

    // Command fields of the access in flight, frozen at grant time.
    logic                  acc_wen;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_W-1:0]     acc_wdata;
    logic [STRB_W-1:0]     acc_wstrb;

    // Command fields of the requester about to be granted.
    logic                  sel_wen;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_W-1:0]     sel_wdata;
    logic [STRB_W-1:0]     sel_wstrb;

    logic [DATA_W-1:0]     rdata_reg;

    // -----------------------------------------------------------------------
    // Arbitration: a lone requester wins outright; on a tie the requester
    // that did not win last time goes first.
    // -----------------------------------------------------------------------
    always_comb begin
        any_req    = r0_req_i | r1_req_i;
        grant_next = 1'b0;
        if (r0_req_i && r1_req_i) begin
            grant_next = ~last_grant;
        end else if (r1_req_i) begin
            grant_next = 1'b1;
        end

        sel_wen   = r0_wen_i;
        sel_addr  = r0_addr_i;
        sel_wdata = r0_wdata_i;
        sel_wstrb = r0_wstrb_i;
        if (grant_next) begin
            sel_wen   = r1_wen_i;
            sel_addr  = r1_addr_i;
            sel_wdata = r1_wdata_i;
            sel_wstrb = r1_wstrb_i;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. Requests are only looked at in IDLE; the rest of the
    // sequence advances unconditionally.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State, grant bookkeeping and captured command/read data. last_grant
    // resets to r1 so the first contended grant after reset goes to r0.
    // -----------------------------------------------------------------------
    always_ff @(posedge axi_aclk_i or negedge axi_aresetn_i) begin
        if (!axi_aresetn_i) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            acc_wen    <= 1'b0;
            acc_addr   <= '0;
            acc_wdata  <= '0;
            acc_wstrb  <= '0;
            rdata_reg  <= '0;
        end else begin
            state <= state_next;

            if (state == IDLE && any_req) begin
                grant      <= grant_next;
                last_grant <= grant_next;
                acc_wen    <= sel_wen;
                acc_addr   <= sel_addr;
                acc_wdata  <= sel_wdata;
                acc_wstrb  <= sel_wstrb;
            end

            // Writes leave the last read value in place.
            if (state == WAIT && !acc_wen) begin
                rdata_reg <= ram_rdata_i;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: registers, or registers gated by a state decode. Strobes and
    // write enable are forced low on reads and outside ISSUE.
    // -----------------------------------------------------------------------
    always_comb begin
        ram_en_o    = (state == ISSUE);
        ram_wen_o   = (state == ISSUE) && acc_wen;
        ram_wstrb_o = ((state == ISSUE) && acc_wen) ? acc_wstrb : '0;
        ram_addr_o  = acc_addr;
        ram_wdata_o = acc_wdata;
        r0_done_o   = (state == DONE) && !grant;
        r1_done_o   = (state == DONE) && grant;
        busy_o      = (state != IDLE);
        rdata_o     = rdata_reg;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          r0_req, r0_wen, r1_req, r1_wen;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [31:0]   r0_wdata, r1_wdata;
    logic [3:0]    r0_wstrb, r1_wstrb;
    logic          r0_done, r1_done;
    logic [31:0]   rdata;
    logic          busy;
    logic          ram_en, ram_wen;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [3:0]    ram_wstrb;
    logic [31:0]   ram_rdata = 32'h0BAD_F00D;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_WIDTH(AW)) dut (
        .axi_aclk_i   (clk),
        .axi_aresetn_i(rst_n),
        .r0_req_i     (r0_req),
        .r0_wen_i     (r0_wen),
        .r0_addr_i    (r0_addr),
        .r0_wdata_i   (r0_wdata),
        .r0_wstrb_i   (r0_wstrb),
        .r0_done_o    (r0_done),
        .r1_req_i     (r1_req),
        .r1_wen_i     (r1_wen),
        .r1_addr_i    (r1_addr),
        .r1_wdata_i   (r1_wdata),
        .r1_wstrb_i   (r1_wstrb),
        .r1_done_o    (r1_done),
        .rdata_o      (rdata),
        .busy_o       (busy),
        .ram_en_o     (ram_en),
        .ram_wen_o    (ram_wen),
        .ram_addr_o   (ram_addr),
        .ram_wdata_o  (ram_wdata),
        .ram_wstrb_o  (ram_wstrb),
        .ram_rdata_i  (ram_rdata)
    );

    typedef struct packed {
        logic          wen;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    wstrb;
    } ram_exp_t;

    typedef struct packed {
        logic        who;
        logic [31:0] rdata;
    } done_exp_t;

    ram_exp_t  ram_q[$];
    done_exp_t done_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_count = 0;
    int done_cyc = -1;
    int en_cyc_last = -1;
    int en_cyc_prev = -1;
    logic prev_en = 1'b0;

    logic [31:0] mem [0:(1<<AW)-1];

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: read data valid only in the cycle after a read enable.
    always @(posedge clk) begin
        if (ram_en && ram_wen) begin
            for (int b = 0; b < 4; b++)
                if (ram_wstrb[b]) mem[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
            ram_rdata <= 32'h0BAD_F00D;
        end else if (ram_en) begin
            ram_rdata <= mem[ram_addr];
        end else begin
            ram_rdata <= 32'h0BAD_F00D;
        end
    end

    // Monitor: pops scoreboard entries whenever the DUT produces output.
    always @(negedge clk) begin
        ram_exp_t  re, ro;
        done_exp_t de, dobs;
        if (rst_n) begin
            if (ram_en) begin
                checks++;
                assert (!prev_en) else begin
                    errors++;
                    $error("FAIL ram_en_width: observed %b expected %b", prev_en, 1'b0);
                end
                en_cyc_prev = en_cyc_last;
                en_cyc_last = cyc;
                checks++;
                assert (ram_q.size() != 0) else begin
                    errors++;
                    $error("FAIL ram_unexpected: observed %0d expected %0d", 1, 0);
                end
                if (ram_q.size() != 0) begin
                    re = ram_q.pop_front();
                    ro.wen   = ram_wen;
                    ro.addr  = ram_addr;
                    ro.wdata = ram_wen ? ram_wdata : 32'h0;
                    ro.wstrb = ram_wstrb;
                    checks++;
                    assert (ro === re) else begin
                        errors++;
                        $error("FAIL ram_access: observed %h expected %h", ro, re);
                    end
                end
            end else begin
                checks++;
                assert ({ram_wen, ram_wstrb} === 5'b0) else begin
                    errors++;
                    $error("FAIL ram_idle_ctrl: observed %b expected %b", {ram_wen, ram_wstrb}, 5'b0);
                end
            end
            prev_en = ram_en;

            if (r0_done || r1_done) begin
                done_count++;
                done_cyc = cyc;
                checks++;
                assert (!(r0_done && r1_done)) else begin
                    errors++;
                    $error("FAIL done_exclusive: observed %b expected one-hot", {r1_done, r0_done});
                end
                checks++;
                assert (done_q.size() != 0) else begin
                    errors++;
                    $error("FAIL done_unexpected: observed %b expected none", {r1_done, r0_done});
                end
                if (done_q.size() != 0) begin
                    de = done_q.pop_front();
                    dobs.who   = r1_done;
                    dobs.rdata = rdata;
                    checks++;
                    assert (dobs === de) else begin
                        errors++;
                        $error("FAIL done_result: observed %h expected %h", dobs, de);
                    end
                end
            end
        end else begin
            prev_en = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_ram(input logic wen, input logic [AW-1:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb);
        ram_exp_t e;
        e.wen   = wen;
        e.addr  = addr;
        e.wdata = wen ? wdata : 32'h0;
        e.wstrb = wen ? wstrb : 4'h0;
        ram_q.push_back(e);
    endtask

    task automatic push_done(input logic who, input logic [31:0] exp_rdata);
        done_exp_t e;
        e.who   = who;
        e.rdata = exp_rdata;
        done_q.push_back(e);
    endtask

    task automatic drive(input logic who, input logic req, input logic wen,
                         input logic [AW-1:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb);
        if (who) begin
            r1_req = req; r1_wen = wen; r1_addr = addr; r1_wdata = wdata; r1_wstrb = wstrb;
        end else begin
            r0_req = req; r0_wen = wen; r0_addr = addr; r0_wdata = wdata; r0_wstrb = wstrb;
        end
    endtask

    // Returns #1 after the edge that leaves DONE, i.e. inside the next IDLE cycle.
    task automatic wait_dones(input int n);
        int target;
        int t;
        target = done_count + n;
        t = 0;
        while (done_count < target && t < 40 * n) begin
            @(posedge clk);
            t++;
        end
        chk("done_timeout", 64'(done_count >= target), 64'd1);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c0;
        int dc;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
        mem[14'h0010] = 32'hDEAD_BEEF;
        mem[14'h3FFF] = 32'hAABB_CCDD;
        mem[14'h0100] = 32'h5555_5555;
        mem[14'h0200] = 32'h2222_2222;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ram_en",    64'(ram_en),    64'd0);
        chk("rst_ram_wen",   64'(ram_wen),   64'd0);
        chk("rst_ram_addr",  64'(ram_addr),  64'd0);
        chk("rst_ram_wdata", 64'(ram_wdata), 64'd0);
        chk("rst_ram_wstrb", 64'(ram_wstrb), 64'd0);
        chk("rst_done",      64'({r1_done, r0_done}), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_rdata",     64'(rdata),     64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // r0 single read, latency from IDLE seeing req to done
        drive(1'b0, 1'b1, 1'b0, 14'h0010, 32'h0, 4'h0);
        c0 = cyc;
        push_ram(1'b0, 14'h0010, 32'h0, 4'h0);
        push_done(1'b0, 32'hDEAD_BEEF);
        wait_dones(1);
        r0_req = 1'b0;
        chk("read_latency", 64'(done_cyc - c0), 64'd3);
        chk("idle_busy", 64'(busy), 64'd0);

        // r1 partial write to top address; rdata holds across the write
        drive(1'b1, 1'b1, 1'b1, 14'h3FFF, 32'h1234_5678, 4'h3);
        push_ram(1'b1, 14'h3FFF, 32'h1234_5678, 4'h3);
        push_done(1'b1, 32'hDEAD_BEEF);
        wait_dones(1);
        r1_req = 1'b0;

        // r0 readback: only the two low byte lanes changed
        drive(1'b0, 1'b1, 1'b0, 14'h3FFF, 32'h0, 4'h0);
        push_ram(1'b0, 14'h3FFF, 32'h0, 4'h0);
        push_done(1'b0, 32'hAABB_5678);
        wait_dones(1);
        r0_req = 1'b0;

        // r0 write whose inputs change during ISSUE and WAIT
        drive(1'b0, 1'b1, 1'b1, 14'h0100, 32'hCAFE_F00D, 4'hF);
        push_ram(1'b1, 14'h0100, 32'hCAFE_F00D, 4'hF);
        push_done(1'b0, 32'hAABB_5678);
        @(posedge clk);
        #1 drive(1'b0, 1'b1, 1'b0, 14'h0200, 32'h1111_1111, 4'h0);
        @(posedge clk);
        #1 drive(1'b0, 1'b1, 1'b1, 14'h3FFF, 32'h9999_9999, 4'h1);
        wait_dones(1);
        r0_req = 1'b0;
        chk("unchanged_0200", 64'(mem[14'h0200]), 64'h2222_2222);

        drive(1'b0, 1'b1, 1'b0, 14'h0100, 32'h0, 4'h0);
        push_ram(1'b0, 14'h0100, 32'h0, 4'h0);
        push_done(1'b0, 32'hCAFE_F00D);
        wait_dones(1);
        r0_req = 1'b0;

        // r0 holds req through done: back-to-back accesses 4 cycles apart
        drive(1'b0, 1'b1, 1'b0, 14'h0010, 32'h0, 4'h0);
        push_ram(1'b0, 14'h0010, 32'h0, 4'h0);
        push_ram(1'b0, 14'h0010, 32'h0, 4'h0);
        push_done(1'b0, 32'hDEAD_BEEF);
        push_done(1'b0, 32'hDEAD_BEEF);
        wait_dones(2);
        r0_req = 1'b0;
        chk("en_spacing", 64'(en_cyc_last - en_cyc_prev), 64'd4);

        // Reset pulsed mid-WAIT of a read: access aborted, outputs clear at once
        drive(1'b0, 1'b1, 1'b0, 14'h3FFF, 32'h0, 4'h0);
        push_ram(1'b0, 14'h3FFF, 32'h0, 4'h0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        r0_req = 1'b0;
        #1;
        chk("abort_ram_en", 64'(ram_en), 64'd0);
        chk("abort_busy",   64'(busy),   64'd0);
        chk("abort_done",   64'({r1_done, r0_done}), 64'd0);
        chk("abort_rdata",  64'(rdata),  64'd0);
        dc = done_count;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(done_count), 64'(dc));

        drive(1'b1, 1'b1, 1'b0, 14'h0010, 32'h0, 4'h0);
        push_ram(1'b0, 14'h0010, 32'h0, 4'h0);
        push_done(1'b1, 32'hDEAD_BEEF);
        wait_dones(1);
        r1_req = 1'b0;

        // Continuous contention from reset: r0 first, then strict alternation
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 14'h0010, 32'h0, 4'h0);
        drive(1'b1, 1'b1, 1'b0, 14'h3FFF, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            push_ram(1'b0, 14'h0010, 32'h0, 4'h0);
            push_done(1'b0, 32'hDEAD_BEEF);
            push_ram(1'b0, 14'h3FFF, 32'h0, 4'h0);
            push_done(1'b1, 32'hAABB_5678);
        end
        wait_dones(8);
        r0_req = 1'b0;
        r1_req = 1'b0;

        repeat (6) @(posedge clk);
        #1;
        chk("ram_q_drained",  64'(ram_q.size()),  64'd0);
        chk("done_q_drained", 64'(done_q.size()), 64'd0);
        chk("final_busy",     64'(busy),          64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
